// File: rtl/mask_iter32_pkg.sv
// mask_iter32_pkg: shared constants and state encoding for the mask bit-scan iterator.
package mask_iter32_pkg;
    localparam int MASK_W = 32;
    localparam int IDX_W  = 5;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    function automatic logic [IDX_W:0] popcount(input logic [MASK_W-1:0] m);
        popcount = '0;
        for (int i = 0; i < MASK_W; i++) popcount += (IDX_W+1)'(m[i]);
    endfunction
endpackage

// File: rtl/mask_iter32_if.sv
// mask_iter32_if: mask input / index output handshake bundle; out_cnt exists only with MASK_ITER_COUNT_EN.
interface mask_iter32_if import mask_iter32_pkg::*; #(parameter int TAG_W = 4);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [MASK_W-1:0] in_mask;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic [TAG_W-1:0]  out_tag;
    logic              done;
`ifdef MASK_ITER_COUNT_EN
    logic [IDX_W:0]    out_cnt;
    modport master (output flush, in_valid, in_mask, in_tag, out_ready,
                    input in_ready, out_valid, out_idx, out_last, out_tag, done, out_cnt);
    modport slave  (input flush, in_valid, in_mask, in_tag, out_ready,
                    output in_ready, out_valid, out_idx, out_last, out_tag, done, out_cnt);
`else
    modport master (output flush, in_valid, in_mask, in_tag, out_ready,
                    input in_ready, out_valid, out_idx, out_last, out_tag, done);
    modport slave  (input flush, in_valid, in_mask, in_tag, out_ready,
                    output in_ready, out_valid, out_idx, out_last, out_tag, done);
`endif
endinterface

// File: rtl/mask_iter32_pencoder.sv
// pencoder32_5: 32-to-5 lowest-set-bit priority encoder.
module pencoder32_5 import mask_iter32_pkg::*; (
    input  logic [MASK_W-1:0] IN,
    output logic [IDX_W-1:0]  OUT,
    output logic              VALID
);
    always_comb begin
        OUT = '0;
        for (int i = MASK_W - 1; i >= 0; i--) if (IN[i]) OUT = IDX_W'(i);
    end
    assign VALID = |IN;
endmodule

// File: rtl/mask_iter32.sv
// mask_iter32: latches a 32-bit mask and emits set-bit indices lowest first, one per accepted beat.
// Optional MASK_ITER_COUNT_EN adds a registered remaining-bit count output.
module mask_iter32 import mask_iter32_pkg::*; #(parameter int TAG_W = 4) (
    input logic          clk,
    input logic          clr,
    mask_iter32_if.slave bus
);
    state_t            state_q, state_d;
    logic [MASK_W-1:0] rem_q, rem_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  idx;
    logic              enc_valid, busy, fire, last;
`ifdef MASK_ITER_COUNT_EN
    logic [IDX_W:0]    cnt_q, cnt_d;
`endif

    pencoder32_5 u_enc (.IN(rem_q), .OUT(idx), .VALID(enc_valid));

    always_comb begin
        busy    = state_q == BUSY;
        last    = busy && ((rem_q & (rem_q - 1'b1)) == '0);
        fire    = busy && bus.out_ready;
        state_d = state_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        done_d  = 1'b0;
`ifdef MASK_ITER_COUNT_EN
        cnt_d   = cnt_q;
`endif
        // flush wins over both a new mask and a beat firing in the same cycle
        if (bus.flush) begin
            state_d = IDLE;
            rem_d   = '0;
`ifdef MASK_ITER_COUNT_EN
            cnt_d   = '0;
`endif
        end else if (!busy && bus.in_valid) begin
            if (bus.in_mask != '0) begin
                state_d = BUSY;
                rem_d   = bus.in_mask;
                tag_d   = bus.in_tag;
`ifdef MASK_ITER_COUNT_EN
                cnt_d   = popcount(bus.in_mask);
`endif
            end else begin
                done_d = 1'b1;
            end
        end else if (fire) begin
            rem_d = rem_q & ~(MASK_W'(1) << idx);
`ifdef MASK_ITER_COUNT_EN
            cnt_d = cnt_q - 1'b1;
`endif
            if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tag_q   <= '0;
            done_q  <= 1'b0;
`ifdef MASK_ITER_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
`ifdef MASK_ITER_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = !busy;
    assign bus.out_valid = busy;
    assign bus.out_idx   = idx;
    assign bus.out_last  = last;
    assign bus.out_tag   = tag_q;
    assign bus.done      = done_q;
`ifdef MASK_ITER_COUNT_EN
    assign bus.out_cnt   = cnt_q;

    a_cnt_last: assert property (@(posedge clk) disable iff (!clr) last == (cnt_q == 1));
`endif

    a_busy_nonzero: assert property (@(posedge clk) disable iff (!clr) busy |-> (rem_q != '0 && enc_valid));
endmodule

// File: tb/tb_mask_iter32.sv
// tb_mask_iter32: randomized and directed checks of mask_iter32 against a set-bit queue model.
module tb_mask_iter32;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mask_iter32_if #(.TAG_W(4)) bus ();
    mask_iter32 #(.TAG_W(4)) dut (.clk(clk), .clr(clr), .bus(bus));

    task automatic idle_checks(input string nm, input logic exp_done);
        checks++; if (bus.done !== exp_done) begin fails++; $display("FAIL %s done got %b exp %b", nm, bus.done, exp_done); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s out_valid got %b exp 0", nm, bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s in_ready got %b exp 1", nm, bus.in_ready); end
    endtask

    // mode 0: always ready, 1: toggle 1,0,1,0, 2: random
    task automatic run_mask(input logic [31:0] m, input logic [3:0] t, input int mode);
        int   q[$];
        int   cyc;
        logic rdy;
        for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL accept_ready got %b exp 1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_mask = m; bus.in_tag = t; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL beat_valid m=%h got %b exp 1", m, bus.out_valid); end
            checks++; if (bus.out_idx !== 5'(q[0])) begin fails++; $display("FAIL beat_idx m=%h got %0d exp %0d", m, bus.out_idx, q[0]); end
            checks++; if (bus.out_last !== (q.size() == 1)) begin fails++; $display("FAIL beat_last m=%h got %b exp %b", m, bus.out_last, q.size() == 1); end
            checks++; if (bus.out_tag !== t) begin fails++; $display("FAIL beat_tag m=%h got %h exp %h", m, bus.out_tag, t); end
            checks++; if (bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL busy_flags m=%h done %b in_ready %b exp 0 0", m, bus.done, bus.in_ready); end
`ifdef MASK_ITER_COUNT_EN
            checks++; if (bus.out_cnt !== 6'(q.size())) begin fails++; $display("FAIL beat_cnt m=%h got %0d exp %0d", m, bus.out_cnt, q.size()); end
`endif
            rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            if (rdy) void'(q.pop_front());
            cyc++;
            @(negedge clk);
        end
        checks++; if (q.size() != 0) begin fails++; $display("FAIL beat_timeout m=%h left %0d exp 0", m, q.size()); end
        bus.out_ready = 1'b0;
        idle_checks("end_done", 1'b1);
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_pulse got %b exp 0", bus.done); end
    endtask

    task automatic test_reset;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_mask = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        clr = 1'b0;
        #12;
        idle_checks("reset", 1'b0);
        checks++; if (bus.out_idx !== 5'd0 || bus.out_last !== 1'b0 || bus.out_tag !== 4'd0) begin fails++; $display("FAIL reset_outs idx %0d last %b tag %h exp 0 0 0", bus.out_idx, bus.out_last, bus.out_tag); end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_directed;
        run_mask(32'h0000_0000, 4'h1, 0);
        run_mask(32'h0000_8421, 4'h3, 0);
        run_mask(32'h8000_0000, 4'h7, 0);
        run_mask(32'hFFFF_FFFF, 4'hA, 1);
    endtask

    task automatic test_random;
        logic [31:0] m;
        for (int n = 0; n < 12; n++) begin
            m = n % 3 == 0 ? $urandom() & $urandom() & $urandom() : $urandom();
            run_mask(m, 4'($urandom_range(0, 15)), 2);
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 32'h8000_0001; bus.in_tag = 4'h5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd0) begin fails++; $display("FAIL flush_first valid %b idx %0d exp 1 0", bus.out_valid, bus.out_idx); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_idx !== 5'd31) begin fails++; $display("FAIL flush_second idx %0d exp 31", bus.out_idx); end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        idle_checks("flush_idle", 1'b0);
        @(negedge clk);
        idle_checks("flush_after", 1'b0);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 32'h00F0_0000; bus.in_tag = 4'h9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_idx !== 5'd20) begin fails++; $display("FAIL rst_first idx %0d exp 20", bus.out_idx); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        idle_checks("async_rst", 1'b0);
        checks++; if (bus.out_idx !== 5'd0 || bus.out_last !== 1'b0 || bus.out_tag !== 4'd0) begin fails++; $display("FAIL async_rst_outs idx %0d last %b tag %h exp 0 0 0", bus.out_idx, bus.out_last, bus.out_tag); end
        @(negedge clk);
        clr = 1'b1; bus.out_ready = 1'b0;
        run_mask(32'h0000_0002, 4'h6, 0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 32'h3; bus.in_tag = 4'h2; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_mask = 32'h4; bus.in_tag = 4'hC;
        checks++; if (bus.out_idx !== 5'd0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_0 idx %0d in_ready %b exp 0 0", bus.out_idx, bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_idx !== 5'd1 || bus.out_last !== 1'b1 || bus.out_tag !== 4'h2) begin fails++; $display("FAIL b2b_1 idx %0d last %b tag %h exp 1 1 2", bus.out_idx, bus.out_last, bus.out_tag); end
        @(negedge clk);
        idle_checks("b2b_gap", 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd2 || bus.out_last !== 1'b1 || bus.out_tag !== 4'hC) begin fails++; $display("FAIL b2b_2 valid %b idx %0d last %b tag %h exp 1 2 1 c", bus.out_valid, bus.out_idx, bus.out_last, bus.out_tag); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        idle_checks("b2b_done", 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
